// File: rtl/starflux_pkg.sv
// Shared types and helpers for the starflux game-logic blocks:
// the game-state encoding, widths and the saturating BCD adder.
package starflux_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    COOLDOWN = 2'd2,
    OVER     = 2'd3
  } game_state_t;

  localparam int          BCD_DIGITS    = 4;
  localparam int          HEALTH_W      = 3;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

  // Adds inc to the low digit and ripples decimal carries upward; a carry out
  // of the top digit clamps the result at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_sat_add(input logic [15:0] a, input logic [3:0] inc);
    logic [15:0] r;
    logic [4:0]  d;
    logic        c;
    r = 16'h0000;
    c = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {4'd0, c} + ((i == 0) ? {1'b0, inc} : 5'd0);
      if (d > 5'd9) begin
        d = d - 5'd10;
        r[i*4 +: 4] = d[3:0];
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c = 1'b0;
      end
    end
    if (c) begin
      r = SCORE_MAX_BCD;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; emits one
// single-cycle event per low-to-high transition of the incoming level.
module pulse_sync (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic event_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser chain plus the previous-value flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= level;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign event_pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/score_health_tracker.sv
// Turns collision-handler score/health levels into events, keeps the BCD
// score and health for the HUD, and runs the IDLE/PLAY/COOLDOWN/OVER FSM.
module score_health_tracker
  import starflux_pkg::*;
#(
  parameter logic [HEALTH_W-1:0] HEALTH_INIT     = 3'd3,
  parameter logic [27:0]         HIT_COOLDOWN    = 28'd50_000_000,
  parameter logic [3:0]          POINTS_PER_KILL = 4'd1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_game,
  input  logic                score_update,
  input  logic                health_update,
  output logic [15:0]         score_bcd,
  output logic [HEALTH_W-1:0] health,
  output logic                playing,
  output logic                hit_flash,
  output logic                game_over,
  output logic                score_pulse
);

  game_state_t          state_r;
  game_state_t          state_next_s;
  logic [15:0]          score_r;
  logic [15:0]          score_next_s;
  logic [HEALTH_W-1:0]  health_r;
  logic [HEALTH_W-1:0]  health_next_s;
  logic [27:0]          count_r;
  logic [27:0]          count_next_s;
  logic                 score_pulse_r;
  logic                 score_pulse_next_s;
  logic                 playing_r;
  logic                 hit_flash_r;
  logic                 game_over_r;
  logic                 score_ev_s;
  logic                 health_ev_s;

  pulse_sync u_score_sync (
    .clock       (clock),
    .reset       (reset),
    .level       (score_update),
    .event_pulse (score_ev_s)
  );

  pulse_sync u_health_sync (
    .clock       (clock),
    .reset       (reset),
    .level       (health_update),
    .event_pulse (health_ev_s)
  );

  // Next-state, score/health update and cooldown counting.
  always_comb begin
    state_next_s       = state_r;
    score_next_s       = score_r;
    health_next_s      = health_r;
    count_next_s       = count_r;
    score_pulse_next_s = 1'b0;

    if (start_game) begin
      state_next_s  = PLAY;
      score_next_s  = 16'h0000;
      health_next_s = HEALTH_INIT;
      count_next_s  = 28'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        PLAY, COOLDOWN: begin
          // Kills count in both active states; no strobe once saturated.
          if (score_ev_s && (score_r != SCORE_MAX_BCD)) begin
            score_next_s       = bcd_sat_add(score_r, POINTS_PER_KILL);
            score_pulse_next_s = 1'b1;
          end else begin
            score_next_s       = score_r;
            score_pulse_next_s = 1'b0;
          end

          if (state_r == COOLDOWN) begin
            if (count_r == 28'd0) begin
              state_next_s = PLAY;
            end else begin
              count_next_s = count_r - 28'd1;
            end
          end else if (health_ev_s && (health_r != {HEALTH_W{1'b0}})) begin
            health_next_s = health_r - {{(HEALTH_W-1){1'b0}}, 1'b1};
            if (health_r == {{(HEALTH_W-1){1'b0}}, 1'b1}) begin
              state_next_s = OVER;
            end else begin
              state_next_s = COOLDOWN;
              count_next_s = HIT_COOLDOWN - 28'd1;
            end
          end else begin
            state_next_s = PLAY;
          end
        end
        OVER: begin
          state_next_s = OVER;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      score_r       <= 16'h0000;
      health_r      <= {HEALTH_W{1'b0}};
      count_r       <= 28'd0;
      score_pulse_r <= 1'b0;
      playing_r     <= 1'b0;
      hit_flash_r   <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      score_r       <= score_next_s;
      health_r      <= health_next_s;
      count_r       <= count_next_s;
      score_pulse_r <= score_pulse_next_s;
      playing_r     <= (state_next_s == PLAY) || (state_next_s == COOLDOWN);
      hit_flash_r   <= (state_next_s == COOLDOWN);
      game_over_r   <= (state_next_s == OVER);
    end
  end

  assign score_bcd   = score_r;
  assign health      = health_r;
  assign playing     = playing_r;
  assign hit_flash   = hit_flash_r;
  assign game_over   = game_over_r;
  assign score_pulse = score_pulse_r;

endmodule
